// File: rtl/seq_add16_ctrl_311_pkg.sv
// Shared definitions for the sequential slice adder: controller states and default sizing.
package add_seq_pkg_311;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_SLICE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_add16_ctrl_311_slice.sv
// SLICE-bit ripple-carry adder built from full adders; the single arithmetic unit
// that the controller time-shares across all slices of the operands.
module adder4_slice_311
    import add_seq_pkg_311::*;
#(
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    logic [SLICE:0] carry;

    // Carry ripples LSB to MSB through one full adder per bit.
    always_comb begin
        carry[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            s[i]         = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[SLICE];
    end

endmodule

// File: rtl/seq_add16_ctrl_311.sv
// Sequential WIDTH-bit add/subtract unit: one SLICE-bit adder is reused for
// WIDTH/SLICE cycles, with a valid/ready request side and a valid/ready result side.
module seq_add16_ctrl_311
    import add_seq_pkg_311::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int MSB    = WIDTH - 1;
    localparam logic [KW-1:0] LAST_K = KW'(NSLICE - 1);

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [SLICE-1:0] sliceA, sliceB, sliceSum;
    logic             sliceCout;

    assign sliceA = opA_q[int'(k_q) * SLICE +: SLICE];
    assign sliceB = opB_q[int'(k_q) * SLICE +: SLICE];

    adder4_slice_311 #(
        .SLICE (SLICE)
    ) u_slice (
        .a    (sliceA),
        .b    (sliceB),
        .cin  (carry_q),
        .s    (sliceSum),
        .cout (sliceCout)
    );

    // Subtraction is A + ~B + 1: B is inverted at accept and the carry seeded with sub.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opA_d   = a;
                    opB_d   = sub ? ~b : b;
                    carry_d = sub;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(k_q) * SLICE +: SLICE] = sliceSum;
                carry_d = sliceCout;
                k_d     = k_q + 1'b1;
                if (k_q == LAST_K) begin
                    k_d     = '0;
                    cout_d  = sliceCout;
                    ovf_d   = (opA_q[MSB] == opB_q[MSB]) && (sliceSum[SLICE-1] != opA_q[MSB]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            opA_q   <= '0;
            opB_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/seq_add16_ctrl_311.md
SEQ_ADD16_CTRL_311 -- requirements
Module: seq_add16_ctrl_311

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width; SHALL be a multiple of SLICE.
REQ-002 Parameter SLICE, default 4: width of the shared adder slice used per cycle.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 b  input  WIDTH  operand B.
REQ-009 sub  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 s  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-013 cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
REQ-014 ovf  output  1  signed overflow.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 IDLE: in_ready=1; a request is accepted when in_valid&in_ready at the clock edge.
REQ-017 On accept: latch A; latch B, or ~B when sub=1; set carry register to sub; clear slice index k; go to RUN.
REQ-018 RUN: in_ready=0; each cycle adds slice k of A, B' and carry through one SLICE-bit adder, writes the slice sum to s[k*SLICE +: SLICE], stores the slice carry-out, and increments k.
REQ-019 After slice WIDTH/SLICE-1 (4 RUN cycles at defaults), go to DONE; cout = final carry.
REQ-020 ovf = (A[MSB] == B'[MSB]) && (s[MSB] != A[MSB]), using the latched operands.
REQ-021 DONE: out_valid=1; s, cout and ovf SHALL hold stable until out_valid&out_ready; then go to IDLE.
REQ-022 Latency: accept at edge N; out_valid high from after edge N+4 (defaults); minimum 6 cycles between accepts.
REQ-023 in_ready SHALL be 0 in DONE even when out_ready=1; no same-cycle accept-and-retire.
REQ-024 Inputs a, b and sub are ignored outside the accepting edge; changes during RUN/DONE SHALL NOT affect the result.
REQ-025 s SHALL be updated only by RUN slice writes; outside RUN it holds its last value.

Reset
REQ-026 When rst=1 at an edge: state=IDLE, k=0, carry=0, s=0, cout=0, ovf=0, out_valid=0; in_ready=1 from the next cycle.
REQ-027 Reset in RUN or DONE SHALL abort the operation; no out_valid SHALL be produced for it.
REQ-028 rst SHALL take priority over in_valid and out_ready at the same edge.

Structure
REQ-029 Package add_seq_pkg_311 SHALL hold the state enum (IDLE/RUN/DONE) and the default WIDTH/SLICE constants.
REQ-030 The datapath SHALL instantiate exactly one sub-module, adder4_slice_311: a SLICE-bit ripple-carry adder of full adders with ports a, b, cin, s, cout.
REQ-031 No WIDTH-wide adder SHALL be inferred; all arithmetic goes through the shared slice.

Verification
REQ-032 ADD 0x1234+0x4321 -> s=0x5555, cout=0, ovf=0; out_valid exactly 4 cycles after the accept edge.
REQ-033 ADD 0xFFFF+0x0001 -> s=0x0000, cout=1, ovf=0; ADD 0x7FFF+0x0001 -> s=0x8000, cout=0, ovf=1.
REQ-034 SUB 0x0005-0x0007 -> s=0xFFFE, cout=0, ovf=0; SUB 0x8000-0x0001 -> s=0x7FFF, cout=1, ovf=1.
REQ-035 Backpressure: out_ready=0 for 3 cycles in DONE -> s/cout/ovf/out_valid stable, in_ready=0; in_valid held high -> next accept only in the cycle after retire.
REQ-036 Reset pulse in the 2nd RUN cycle -> next cycle state IDLE, out_valid=0, s=0; a new request then completes correctly.
REQ-037 Random back-to-back traffic (>=1000 ops, random sub/out_ready) checked against a reference model of A±B mod 2^16 with cout/ovf.
